// File: rtl/freqdiv_pkg.sv
// Shared types and helpers for the multi-channel integer clock divider.
package freqdiv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned DIV_MIN = 2;

  // Number of high cycles in a period of n cycles (rounds up for odd n).
  function automatic logic [31:0] half_period(input logic [31:0] n);
    return (n + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/freqdiv_channel.sv
// One divider channel: IDLE/RUN FSM, period counter and shadow divisor.
// Optional FREQDIV_PHASE_SYNC_EN adds a sync input that restarts running channels.
module freqdiv_channel
  import freqdiv_pkg::*;
#(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
`ifdef FREQDIV_PHASE_SYNC_EN
  input  logic             sync,
`endif
  output logic             clk_out,
  output logic             period_done,
  output logic             active
);

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] sh;
  logic [DIV_W-1:0] cnt_inc_c;
  logic [DIV_W-1:0] half_c;
  logic [DIV_W-1:0] last_c;
  logic             legal_c;
  logic             reload_c;

  assign legal_c   = (div >= DIV_W'(DIV_MIN));
  assign reload_c  = en && legal_c;
  assign cnt_inc_c = cnt + DIV_W'(1);
  assign half_c    = DIV_W'(half_period(32'(sh)));
  assign last_c    = sh - DIV_W'(1);
  assign active    = (state == RUN);

  // period_done is registered one edge early so it is high exactly while cnt == sh-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sh          <= '0;
      clk_out     <= 1'b0;
      period_done <= 1'b0;
    end else begin
      period_done <= 1'b0;
`ifdef FREQDIV_PHASE_SYNC_EN
      if (sync && state == RUN) begin
        cnt <= '0;
        if (legal_c) begin
          sh      <= div;
          clk_out <= 1'b1;
        end else begin
          state   <= IDLE;
          clk_out <= 1'b0;
        end
      end else
`endif
      case (state)
        IDLE: begin
          clk_out <= 1'b0;
          if (reload_c) begin
            sh      <= div;
            cnt     <= '0;
            clk_out <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (cnt == last_c) begin
            cnt <= '0;
            if (reload_c) begin
              sh      <= div;
              clk_out <= 1'b1;
            end else begin
              clk_out <= 1'b0;
              state   <= IDLE;
            end
          end else begin
            cnt         <= cnt_inc_c;
            clk_out     <= (cnt_inc_c < half_c);
            period_done <= (cnt_inc_c == last_c);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/freqdiv_multi.sv
// NCH independent programmable clock dividers sharing clock and reset.
// Optional FREQDIV_PHASE_SYNC_EN adds a common sync input.
module freqdiv_multi #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned DIV_W = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [NCH-1:0]       en,
  input  logic [NCH*DIV_W-1:0] div,
`ifdef FREQDIV_PHASE_SYNC_EN
  input  logic                 sync,
`endif
  output logic [NCH-1:0]       clk_out,
  output logic [NCH-1:0]       period_done,
  output logic [NCH-1:0]       active
);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    freqdiv_channel #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk        (wb_clk_i),
      .rst        (wb_rst_i),
      .en         (en[k]),
      .div        (div[k*DIV_W +: DIV_W]),
`ifdef FREQDIV_PHASE_SYNC_EN
      .sync       (sync),
`endif
      .clk_out    (clk_out[k]),
      .period_done(period_done[k]),
      .active     (active[k])
    );
  end

endmodule
